// File: rtl/mcu_rst_ctrl_if.sv
// mcu_rst_ctrl_if
// Groups the reset-request inputs and the generated reset outputs of the
// MCU reset sequencer.
//   slave  : the sequencer side (takes requests, drives resets/cause)
//   master : the environment side (drives requests, observes resets/cause)
// Signals:
//   sysresetreq, wdt_rst_req, sw_rst_req : level reset requests
//   lockup, lockup_rst_en                : core lockup and its reset enable
//   cause_clr                            : one-cycle clear of rst_cause
//   sys_rstn, apb1_rstn                  : active-low domain resets
//   rst_busy                             : sequencer not in RUN
//   rst_cause                            : sticky {lockup, sw, wdt, sysreq, por}
interface mcu_rst_ctrl_if;
  logic       sysresetreq;
  logic       wdt_rst_req;
  logic       sw_rst_req;
  logic       lockup;
  logic       lockup_rst_en;
  logic       cause_clr;
  logic       sys_rstn;
  logic       apb1_rstn;
  logic       rst_busy;
  logic [4:0] rst_cause;

  modport slave (
    input  sysresetreq, wdt_rst_req, sw_rst_req, lockup, lockup_rst_en, cause_clr,
    output sys_rstn, apb1_rstn, rst_busy, rst_cause
  );

  modport master (
    output sysresetreq, wdt_rst_req, sw_rst_req, lockup, lockup_rst_en, cause_clr,
    input  sys_rstn, apb1_rstn, rst_busy, rst_cause
  );
endinterface

// File: rtl/mcu_rst_ctrl.sv
// mcu_rst_ctrl
// Reset sequencer for the full-function domain. Merges SYSRESETREQ, watchdog,
// software and (optionally) lockup requests with power-on reset, holds the
// system and APB1 resets for HOLD_CYCLES after the last request, then releases
// sys_rstn first and apb1_rstn STAGGER_CYCLES later. Records reset causes in a
// sticky register.
// Ports:
//   sys_root_clk  : sole clock, rising edge
//   power_on_rstn : synchronous active-low block reset
//   bus           : mcu_rst_ctrl_if.slave (requests in, resets/cause out)
module mcu_rst_ctrl #(
  parameter int HOLD_CYCLES    = 16,
  parameter int STAGGER_CYCLES = 4,
  parameter int CNT_W          = 8
) (
  input  logic           sys_root_clk,
  input  logic           power_on_rstn,
  mcu_rst_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'd0,
    ST_STAGGER = 2'd1,
    ST_RUN     = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAG_LAST = CNT_W'(STAGGER_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sys_rstn_q, sys_rstn_d;
  logic             apb1_rstn_q, apb1_rstn_d;
  logic             busy_q, busy_d;
  logic [4:0]       cause_q, cause_d;

  logic             lockup_req;
  logic             req_any;
  logic [4:0]       cause_src;

  assign lockup_req = bus.lockup & bus.lockup_rst_en;
  assign req_any    = bus.sysresetreq | bus.wdt_rst_req | bus.sw_rst_req | lockup_req;
  // por bit is only ever set by the block reset itself
  assign cause_src  = {lockup_req, bus.sw_rst_req, bus.wdt_rst_req, bus.sysresetreq, 1'b0};

  always_ff @(posedge sys_root_clk) begin
    if (!power_on_rstn) begin
      state_q     <= ST_ASSERT;
      cnt_q       <= '0;
      sys_rstn_q  <= 1'b0;
      apb1_rstn_q <= 1'b0;
      busy_q      <= 1'b1;
      cause_q     <= 5'b00001;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sys_rstn_q  <= sys_rstn_d;
      apb1_rstn_q <= apb1_rstn_d;
      busy_q      <= busy_d;
      cause_q     <= cause_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sys_rstn_d  = sys_rstn_q;
    apb1_rstn_d = apb1_rstn_q;
    unique case (state_q)
      ST_ASSERT: begin
        sys_rstn_d  = 1'b0;
        apb1_rstn_d = 1'b0;
        if (req_any) begin
          // a held request keeps restarting the hold window
          cnt_d = '0;
        end else if (cnt_q == HOLD_LAST) begin
          state_d    = ST_STAGGER;
          cnt_d      = '0;
          sys_rstn_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_STAGGER: begin
        if (req_any) begin
          state_d     = ST_ASSERT;
          cnt_d       = '0;
          sys_rstn_d  = 1'b0;
          apb1_rstn_d = 1'b0;
        end else if (cnt_q == STAG_LAST) begin
          state_d     = ST_RUN;
          cnt_d       = '0;
          apb1_rstn_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        if (req_any) begin
          state_d     = ST_ASSERT;
          cnt_d       = '0;
          sys_rstn_d  = 1'b0;
          apb1_rstn_d = 1'b0;
        end
      end
      default: begin
        state_d     = ST_ASSERT;
        cnt_d       = '0;
        sys_rstn_d  = 1'b0;
        apb1_rstn_d = 1'b0;
      end
    endcase
    // busy is registered off the next state so it drops on the apb1 release edge
    busy_d  = (state_d != ST_RUN);
    // same-cycle source set wins over the clear
    cause_d = (bus.cause_clr ? 5'b00000 : cause_q) | cause_src;
  end

  assign bus.sys_rstn  = sys_rstn_q;
  assign bus.apb1_rstn = apb1_rstn_q;
  assign bus.rst_busy  = busy_q;
  assign bus.rst_cause = cause_q;

endmodule
